// File: rtl/pong_ball_if.sv
// Frame-level signals between the ball controller, its frame/collision sources
// and the ball sprite / score display consumers.
interface pong_ball_if;
  logic       vsync_i;
  logic       collision_i;
  logic       start_i;
  logic [9:0] ball_x_o;
  logic [9:0] ball_y_o;
  logic [3:0] score_1_o;
  logic [3:0] score_2_o;
  logic       point_1_o;
  logic       point_2_o;
  logic       game_over_o;

  modport master (
    output vsync_i, collision_i, start_i,
    input  ball_x_o, ball_y_o, score_1_o, score_2_o,
    input  point_1_o, point_2_o, game_over_o
  );

  modport slave (
    input  vsync_i, collision_i, start_i,
    output ball_x_o, ball_y_o, score_1_o, score_2_o,
    output point_1_o, point_2_o, game_over_o
  );
endinterface

// File: rtl/pong_ball_ctrl.sv
// Pong ball motion and scoring: once per frame (vsync falling edge) reflects,
// moves or recentres the ball and keeps both scores until one side wins.
module pong_ball_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 2,
  parameter int PADDLE_ZONE  = 24,
  parameter int SERVE_FRAMES = 60,
  parameter int MAX_SCORE    = 9
) (
  input  logic         clk,
  input  logic         rst,
  pong_ball_if.slave   pb
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0]  X_CTR    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CTR    = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  SX10     = 10'(SPEED_X);
  localparam logic [10:0] SX11     = 11'(SPEED_X);
  localparam logic [10:0] BS11     = 11'(BALL_SIZE);
  localparam logic [10:0] HA11     = 11'(H_ACTIVE);
  localparam logic [10:0] PZ_L11   = 11'(PADDLE_ZONE);
  localparam logic [10:0] PZ_R11   = 11'(H_ACTIVE - PADDLE_ZONE);
  localparam logic [10:0] Y_MID11  = 11'(V_ACTIVE / 2);
  localparam logic signed [11:0] SY12   = 12'(SPEED_Y);
  localparam logic signed [11:0] YMAX12 = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic [3:0]  MAX4     = 4'(MAX_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SERVE,
    ST_PLAY,
    ST_GAME_OVER
  } state_e;

  state_e           state_q;
  logic             vsync_q;
  logic [CNT_W-1:0] serve_cnt_q;
  logic             dir_x_q;   // 1 = moving left
  logic             dir_y_q;   // 1 = moving up
  logic [9:0]       ball_x_q;
  logic [9:0]       ball_y_q;
  logic [3:0]       score_1_q;
  logic [3:0]       score_2_q;
  logic             point_1_q;
  logic             point_2_q;
  logic             game_over_q;

  logic                tick;
  logic [10:0]         x11;
  logic [10:0]         y11;
  logic                dir_x_d;
  logic                dir_y_d;
  logic                miss_l;
  logic                miss_r;
  logic [9:0]          ball_x_d;
  logic signed [11:0]  y_mv;
  logic [9:0]          ball_y_d;
  logic                y_clamp_hit;

  function automatic logic [9:0] clamp_y(input logic signed [11:0] y);
    if (y < 12'sd0)
      return 10'd0;
    else if (y > YMAX12)
      return 10'(YMAX12);
    else
      return 10'(y);
  endfunction

  function automatic logic clamp_hit(input logic signed [11:0] y);
    return (y < 12'sd0) || (y > YMAX12);
  endfunction

  assign tick = vsync_q & ~pb.vsync_i;
  assign x11  = {1'b0, ball_x_q};
  assign y11  = {1'b0, ball_y_q};

  // Reflection first (anti-stick: only when moving into the surface), then
  // miss detection against the reflected direction, then the candidate move.
  always_comb begin
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (pb.collision_i && (x11 < PZ_L11) && dir_x_q)
      dir_x_d = 1'b0;
    else if (pb.collision_i && (x11 + BS11 > PZ_R11) && !dir_x_q)
      dir_x_d = 1'b1;
    else if (pb.collision_i && (y11 < Y_MID11) && dir_y_q)
      dir_y_d = 1'b0;
    else if (pb.collision_i && (y11 >= Y_MID11) && !dir_y_q)
      dir_y_d = 1'b1;

    miss_l = dir_x_d && (x11 <= SX11);
    miss_r = !dir_x_d && (x11 + BS11 + SX11 >= HA11);

    ball_x_d    = dir_x_d ? (ball_x_q - SX10) : (ball_x_q + SX10);
    y_mv        = dir_y_d ? ($signed({2'b00, ball_y_q}) - SY12)
                          : ($signed({2'b00, ball_y_q}) + SY12);
    ball_y_d    = clamp_y(y_mv);
    y_clamp_hit = clamp_hit(y_mv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SERVE;
      vsync_q     <= 1'b0;
      serve_cnt_q <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      ball_x_q    <= X_CTR;
      ball_y_q    <= Y_CTR;
      score_1_q   <= 4'd0;
      score_2_q   <= 4'd0;
      point_1_q   <= 1'b0;
      point_2_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      vsync_q   <= pb.vsync_i;
      point_1_q <= 1'b0;
      point_2_q <= 1'b0;
      case (state_q)
        ST_SERVE: begin
          if (tick) begin
            if (serve_cnt_q == SERVE_LAST) begin
              serve_cnt_q <= '0;
              state_q     <= ST_PLAY;
            end else begin
              serve_cnt_q <= serve_cnt_q + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (tick) begin
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            if (miss_l) begin
              score_2_q <= score_2_q + 4'd1;
              point_2_q <= 1'b1;
              ball_x_q  <= X_CTR;
              ball_y_q  <= Y_CTR;
              dir_x_q   <= 1'b1;
              if (score_2_q + 4'd1 == MAX4) begin
                state_q     <= ST_GAME_OVER;
                game_over_q <= 1'b1;
              end else begin
                state_q <= ST_SERVE;
              end
            end else if (miss_r) begin
              score_1_q <= score_1_q + 4'd1;
              point_1_q <= 1'b1;
              ball_x_q  <= X_CTR;
              ball_y_q  <= Y_CTR;
              dir_x_q   <= 1'b0;
              if (score_1_q + 4'd1 == MAX4) begin
                state_q     <= ST_GAME_OVER;
                game_over_q <= 1'b1;
              end else begin
                state_q <= ST_SERVE;
              end
            end else begin
              ball_x_q <= ball_x_d;
              ball_y_q <= ball_y_d;
              if (y_clamp_hit)
                dir_y_q <= ~dir_y_d;
            end
          end
        end
        ST_GAME_OVER: begin
          if (pb.start_i) begin
            score_1_q   <= 4'd0;
            score_2_q   <= 4'd0;
            game_over_q <= 1'b0;
            serve_cnt_q <= '0;
            state_q     <= ST_SERVE;
          end
        end
        default: state_q <= ST_SERVE;
      endcase
    end
  end

  assign pb.ball_x_o    = ball_x_q;
  assign pb.ball_y_o    = ball_y_q;
  assign pb.score_1_o   = score_1_q;
  assign pb.score_2_o   = score_2_q;
  assign pb.point_1_o   = point_1_q;
  assign pb.point_2_o   = point_2_q;
  assign pb.game_over_o = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: a frame-level reference model pushes expected
// outputs per clock into a queue that is popped against the DUT.
module tb_pong_ball_ctrl;

  logic clk;
  logic rst;
  pong_ball_if pb();

  pong_ball_ctrl dut (
    .clk (clk),
    .rst (rst),
    .pb  (pb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       p1;
    logic       p2;
    logic       go;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // reference model state; st: 0 serve, 1 play, 2 game over
  int m_x, m_y, m_s1, m_s2, m_cnt, m_st;
  bit m_dl, m_du, m_p1, m_p2, m_go;
  bit stick;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_x = 316; m_y = 236; m_dl = 0; m_du = 0;
    m_s1 = 0; m_s2 = 0; m_cnt = 0; m_st = 0;
    m_p1 = 0; m_p2 = 0; m_go = 0;
  endfunction

  function automatic void m_centre();
    m_x = 316; m_y = 236;
  endfunction

  function automatic void m_tick(input bit c);
    bit nl, nu;
    int ny;
    m_p1 = 0; m_p2 = 0;
    if (m_st == 0) begin
      if (m_cnt == 59) begin m_cnt = 0; m_st = 1; end
      else m_cnt++;
    end else if (m_st == 1) begin
      nl = m_dl; nu = m_du;
      if (c && m_x < 24 && m_dl) nl = 0;
      else if (c && m_x + 8 > 616 && !m_dl) nl = 1;
      else if (c && m_y < 240 && m_du) nu = 0;
      else if (c && m_y >= 240 && !m_du) nu = 1;
      m_dl = nl; m_du = nu;
      if (nl && m_x <= 2) begin
        m_s2++; m_p2 = 1; m_centre(); m_dl = 1;
        if (m_s2 == 9) begin m_st = 2; m_go = 1; end else m_st = 0;
      end else if (!nl && m_x + 10 >= 640) begin
        m_s1++; m_p1 = 1; m_centre(); m_dl = 0;
        if (m_s1 == 9) begin m_st = 2; m_go = 1; end else m_st = 0;
      end else begin
        m_x = nl ? m_x - 2 : m_x + 2;
        ny  = nu ? m_y - 2 : m_y + 2;
        if (ny < 0) begin ny = 0; m_du = !m_du; end
        else if (ny > 472) begin ny = 472; m_du = !m_du; end
        m_y = ny;
      end
    end
  endfunction

  function automatic void push_exp(input bit with_pulse);
    exp_t e;
    e.x  = 10'(m_x);
    e.y  = 10'(m_y);
    e.s1 = 4'(m_s1);
    e.s2 = 4'(m_s2);
    e.p1 = with_pulse ? m_p1 : 1'b0;
    e.p2 = with_pulse ? m_p2 : 1'b0;
    e.go = m_go;
    sb.push_back(e);
  endfunction

  task automatic sample(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_x"},  32'(pb.ball_x_o),    32'(e.x));
    check({tag, "_y"},  32'(pb.ball_y_o),    32'(e.y));
    check({tag, "_s1"}, 32'(pb.score_1_o),   32'(e.s1));
    check({tag, "_s2"}, 32'(pb.score_2_o),   32'(e.s2));
    check({tag, "_p1"}, 32'(pb.point_1_o),   32'(e.p1));
    check({tag, "_p2"}, 32'(pb.point_2_o),   32'(e.p2));
    check({tag, "_go"}, 32'(pb.game_over_o), 32'(e.go));
  endtask

  // collision policy per mode, decided from the pre-tick model state
  function automatic bit coll_for(input int mode);
    if (mode == 1) begin
      if (stick) begin stick = 0; return 1'b1; end
      if (m_st == 1 && m_dl && m_x == 10) begin stick = 1; return 1'b1; end
      return (!m_dl && m_x >= 610) || (m_du && m_y <= 4);
    end else if (mode == 2) begin
      return !m_dl && m_x >= 610;
    end else if (mode == 3) begin
      return m_dl && m_x < 24;
    end else if (mode == 4) begin
      return $urandom_range(0, 3) == 0;
    end
    return 1'b0;
  endfunction

  task automatic frame(input int mode);
    bit c;
    @(negedge clk);
    c = coll_for(mode);
    pb.vsync_i     = 1'b0;
    pb.collision_i = c;
    m_tick(c);
    push_exp(1'b1);
    push_exp(1'b0);
    @(posedge clk); #1;
    sample("tick");
    @(posedge clk); #1;
    sample("post");
    @(negedge clk);
    pb.vsync_i     = 1'b1;
    pb.collision_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frames(input int mode, input int n);
    for (int i = 0; i < n; i++) frame(mode);
  endtask

  task automatic run_until_point(input int mode, input int max_frames);
    bit got;
    got = 0;
    for (int i = 0; i < max_frames; i++) begin
      frame(mode);
      if (m_p1 || m_p2) begin got = 1; break; end
    end
    check("point_reached", 32'(got), 32'd1);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    pb.start_i = 1'b1;
    if (m_st == 2) begin
      m_s1 = 0; m_s2 = 0; m_go = 0; m_cnt = 0; m_st = 0;
    end
    m_p1 = 0; m_p2 = 0;
    push_exp(1'b0);
    @(posedge clk); #1;
    sample("start");
    @(negedge clk);
    pb.start_i = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    pb.vsync_i     = 1'b0;
    pb.collision_i = 1'b0;
    pb.start_i     = 1'b0;
    stick          = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    push_exp(1'b0);
    sample("reset");
    @(negedge clk);
    rst        = 1'b0;
    pb.vsync_i = 1'b1;
    repeat (2) @(negedge clk);

    // serve hold then launch
    run_frames(0, 60);
    check("serve_hold_x", 32'(pb.ball_x_o), 32'd316);
    check("serve_hold_y", 32'(pb.ball_y_o), 32'd236);
    frame(0);
    check("launch_x", 32'(pb.ball_x_o), 32'd318);
    check("launch_y", 32'(pb.ball_y_o), 32'd238);

    // eight right-wall misses: player 1 to 8
    for (int p = 0; p < 8; p++) run_until_point(0, 400);
    check("p1_eight", 32'(pb.score_1_o), 32'd8);

    // rally with paddle bounces, anti-stick repeats and top collisions
    run_frames(1, 500);

    // left miss: player 2 scores
    run_until_point(2, 800);
    check("left_miss_s2", 32'(pb.score_2_o), 32'd1);
    check("left_miss_x",  32'(pb.ball_x_o),  32'd316);

    // right miss ends the game
    run_until_point(3, 800);
    check("game_over", 32'(pb.game_over_o), 32'd1);
    check("final_s1",  32'(pb.score_1_o),   32'd9);

    run_frames(4, 6);
    start_pulse();
    check("restart_go", 32'(pb.game_over_o), 32'd0);

    run_frames(4, 90);
    start_pulse();

    // reset coincident with a vsync falling edge mid-play
    @(negedge clk);
    pb.vsync_i     = 1'b0;
    pb.collision_i = 1'b1;
    rst            = 1'b1;
    m_reset();
    push_exp(1'b0);
    push_exp(1'b0);
    @(posedge clk); #1;
    sample("rst_tick");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sample("rst_after");
    @(negedge clk);
    pb.vsync_i     = 1'b1;
    pb.collision_i = 1'b0;
    repeat (2) @(negedge clk);

    run_frames(4, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
